// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared types for the wave_gen tone generator.
//   wave_mode_t    2-bit waveform select (square, sawtooth, triangle, reserved)
//   wave_cfg_t     one complete configuration word, used for both the shadow
//                  and the active copy
//   shadow_state_t occupancy of the configuration shadow register
// The struct field widths follow cfg_cnt_w / cfg_res_w. The wave_gen
// parameters default to these values and must stay equal to them.
package wave_gen_pkg;

   localparam int cfg_cnt_w = 8;
   localparam int cfg_res_w = 8;

   typedef enum logic [1:0] {
      MODE_SQUARE = 2'd0,
      MODE_SAW    = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_RSVD   = 2'd3
   } wave_mode_t;

   typedef struct packed {
      wave_mode_t           mode;
      logic [cfg_cnt_w-1:0] period;
      logic [cfg_cnt_w-1:0] duty;
      logic [cfg_res_w-1:0] step;
   } wave_cfg_t;

   typedef enum logic {
      SHD_EMPTY = 1'b0,
      SHD_FULL  = 1'b1
   } shadow_state_t;

endpackage

// File: rtl/wave_gen_if.sv
// wave_gen_if: configuration valid/ready channel into wave_gen.
//   cfg_valid  master -> slave  new configuration offered
//   cfg_ready  slave -> master  shadow empty, so an offer is taken this cycle
//   cfg_mode   master -> slave  waveform select
//   cfg_period master -> slave  period in clk cycles
//   cfg_duty   master -> slave  square-wave high time in clk cycles
//   cfg_step   master -> slave  ramp increment per clk
interface wave_gen_if #(
   parameter int counter_width   = 8,
   parameter int resolution_bits = 8
);
   import wave_gen_pkg::*;

   logic                       cfg_valid;
   logic                       cfg_ready;
   wave_mode_t                 cfg_mode;
   logic [counter_width-1:0]   cfg_period;
   logic [counter_width-1:0]   cfg_duty;
   logic [resolution_bits-1:0] cfg_step;

   modport master (
      output cfg_valid, cfg_mode, cfg_period, cfg_duty, cfg_step,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_period, cfg_duty, cfg_step,
      output cfg_ready
   );

endinterface

// File: rtl/wave_phase_counter.sv
// wave_phase_counter: phase counter for wave_gen.
//   clk, reset_n  clock and asynchronous active-low reset
//   enable        1 = advance the counter, 0 = hold
//   period        active period P; P = 0 keeps the counter parked at 0
//   restart       force cnt to 0 on the next edge (a new configuration takes effect)
//   cnt           current phase, counts 0 .. P-1
//   period_end    high during the cycle in which cnt wraps from P-1 to 0
module wave_phase_counter #(
   parameter int counter_width = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [counter_width-1:0] period,
   input  logic                     restart,
   output logic [counter_width-1:0] cnt,
   output logic                     period_end
);

   localparam logic [counter_width-1:0] cnt_one = 1;

   logic [counter_width-1:0] cnt_q, cnt_d;
   logic                     run, wrap;

   always_comb begin
      run   = enable && (period != '0);
      wrap  = run && (cnt_q == (period - cnt_one));
      cnt_d = cnt_q;
      if (restart || (period == '0) || wrap) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + cnt_one;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt        = cnt_q;
   assign period_end = wrap;

endmodule

// File: rtl/wave_gen.sv
// wave_gen: multi-mode tone generator (square with duty, sawtooth, triangle).
//   clk, reset_n  clock and asynchronous active-low reset
//   enable        1 = run, 0 = freeze phase, ramp and output
//   cfg           wave_gen_if.slave configuration channel, held in a one-deep
//                 shadow and moved into the active copy at a period boundary
//   wave_out      registered sample, resolution_bits wide
//   period_end    one-cycle pulse in the cycle the phase counter wraps
// Build option WAVE_GEN_TRIANGLE_EN: when defined, mode 2 produces a triangle.
// When it is undefined, the triangle logic is left out and mode 2 outputs 0,
// the same as the reserved mode.
//
// Shadow FSM
//   state     | meaning
//   SHD_EMPTY | no pending configuration, cfg_ready = 1
//   SHD_FULL  | configuration waiting for the next wrap (or for an idle cycle
//             | when disabled or silent), cfg_ready = 0
module wave_gen
   import wave_gen_pkg::*;
#(
   parameter int resolution_bits = cfg_res_w,
   parameter int counter_width   = cfg_cnt_w
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   wave_gen_if.slave                  cfg,
   output logic [resolution_bits-1:0] wave_out,
   output logic                       period_end
);

   localparam logic [resolution_bits-1:0] wave_max = '1;
   localparam logic [resolution_bits:0]   amp_max  = {1'b0, wave_max};

   shadow_state_t              shd_state_q, shd_state_d;
   wave_cfg_t                  shadow_q, shadow_d;
   wave_cfg_t                  active_q, active_d;
   logic [resolution_bits:0]   amp_q, amp_d;
   logic [resolution_bits-1:0] wave_q, wave_d;

   logic [counter_width-1:0]   cnt;
   logic                       wrap;
   logic                       apply;
   logic                       use_amp;
   logic [resolution_bits:0]   step_ext, amp_sum, amp_rise;
`ifdef WAVE_GEN_TRIANGLE_EN
   logic [resolution_bits:0]   amp_fall;
   logic [counter_width-1:0]   tri_half;
`endif

   wave_phase_counter #(
      .counter_width(counter_width)
   ) u_phase (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .period    (active_q.period),
      .restart   (apply),
      .cnt       (cnt),
      .period_end(wrap)
   );

   // A pending shadow goes live at a wrap while running. When the counter is
   // not advancing there is no wrap to wait for, so it goes live right away.
   assign apply = (shd_state_q == SHD_FULL) &&
                  (wrap || !enable || (active_q.period == '0));

   always_comb begin
      shd_state_d = shd_state_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      case (shd_state_q)
         SHD_EMPTY: begin
            if (cfg.cfg_valid) begin
               shadow_d.mode   = cfg.cfg_mode;
               shadow_d.period = cfg.cfg_period;
               shadow_d.duty   = cfg.cfg_duty;
               shadow_d.step   = cfg.cfg_step;
               shd_state_d     = SHD_FULL;
            end
         end
         SHD_FULL: begin
            if (apply) begin
               active_d    = shadow_q;
               shd_state_d = SHD_EMPTY;
            end
         end
         default: shd_state_d = SHD_EMPTY;
      endcase
   end

   always_comb begin
      step_ext = {1'b0, active_q.step};
      amp_sum  = amp_q + step_ext;
      amp_rise = (amp_sum > amp_max) ? amp_max : amp_sum;
`ifdef WAVE_GEN_TRIANGLE_EN
      amp_fall = (amp_q >= step_ext) ? (amp_q - step_ext) : '0;
      tri_half = active_q.period >> 1;
`endif
      amp_d   = amp_q;
      wave_d  = wave_q;
      use_amp = 1'b0;
      if (active_q.period == '0) begin
         amp_d  = '0;
         wave_d = '0;
      end else if (enable) begin
         case (active_q.mode)
            MODE_SQUARE: begin
               amp_d  = '0;
               wave_d = (cnt < active_q.duty) ? wave_max : '0;
            end
            MODE_SAW: begin
               amp_d   = wrap ? '0 : amp_rise;
               use_amp = 1'b1;
            end
`ifdef WAVE_GEN_TRIANGLE_EN
            MODE_TRI: begin
               if (wrap) begin
                  amp_d = '0;
               end else if (cnt < tri_half) begin
                  amp_d = amp_rise;
               end else begin
                  amp_d = amp_fall;
               end
               use_amp = 1'b1;
            end
`endif
            default: begin
               amp_d  = '0;
               wave_d = '0;
            end
         endcase
         // The ramp output is the updated amplitude, so the first sample of a
         // period already includes one step.
         if (use_amp) begin
            wave_d = (amp_d > amp_max) ? wave_max : amp_d[resolution_bits-1:0];
         end
      end else if (apply) begin
         amp_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shd_state_q <= SHD_EMPTY;
         shadow_q    <= '0;
         active_q    <= '0;
         amp_q       <= '0;
         wave_q      <= '0;
      end else begin
         shd_state_q <= shd_state_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         amp_q       <= amp_d;
         wave_q      <= wave_d;
      end
   end

   assign cfg.cfg_ready = (shd_state_q == SHD_EMPTY);
   assign wave_out      = wave_q;
   assign period_end    = wrap;

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed bench for wave_gen with hand-computed sample tables.
module tb_wave_gen;
   import wave_gen_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic [7:0] wave_out;
   logic       period_end;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] exp_w [16];

   wave_gen_if #(.counter_width(8), .resolution_bits(8)) cfg_if ();

   wave_gen #(
      .resolution_bits(8),
      .counter_width  (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .cfg       (cfg_if),
      .wave_out  (wave_out),
      .period_end(period_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic drive_cfg(input wave_mode_t m, input int p, input int d, input int s);
      cfg_if.cfg_mode   = m;
      cfg_if.cfg_period = 8'(p);
      cfg_if.cfg_duty   = 8'(d);
      cfg_if.cfg_step   = 8'(s);
   endtask

   task automatic send_cfg(input wave_mode_t m, input int p, input int d, input int s);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      drive_cfg(m, p, d, s);
      cfg_if.cfg_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (cfg_if.cfg_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      cfg_if.cfg_valid = 1'b0;
      chk("cfg_accept", 32'(ok), 1);
   endtask

   task automatic wait_ready();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (cfg_if.cfg_ready) ok = 1'b1;
      end
      chk("ready_wait", 32'(ok), 1);
   endtask

   task automatic sync_pe();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (period_end) ok = 1'b1;
      end
      chk("pe_wait", 32'(ok), 1);
   endtask

   // Called right after a period_end negedge; negedge i then sits in the
   // cycle with cnt = i-1 and shows the sample produced by cnt = i-2.
   task automatic collect(input string tag, input int p);
      for (int i = 1; i <= p + 1; i++) begin
         @(negedge clk);
         chk({tag, "_wave"}, 32'(wave_out), 32'(exp_w[(i - 2 + p) % p]));
         chk({tag, "_pe"}, 32'(period_end), 32'(i == p));
      end
   endtask

   task automatic fill(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                       input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] v5,
                       input logic [7:0] v6, input logic [7:0] v7, input logic [7:0] v8,
                       input logic [7:0] v9);
      exp_w[0] = v0; exp_w[1] = v1; exp_w[2] = v2; exp_w[3] = v3; exp_w[4] = v4;
      exp_w[5] = v5; exp_w[6] = v6; exp_w[7] = v7; exp_w[8] = v8; exp_w[9] = v9;
   endtask

   initial begin
      logic exp_r, exp_p;
      reset_n          = 1'b1;
      enable           = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      drive_cfg(MODE_SQUARE, 0, 0, 0);
      #1 reset_n = 1'b0;
      #7;
      chk("rst_wave", 32'(wave_out), 0);
      chk("rst_pe", 32'(period_end), 0);
      chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
      @(negedge clk);
      reset_n = 1'b1;
      enable  = 1'b1;

      // square P=10 D=3
      send_cfg(MODE_SQUARE, 10, 3, 77);
      wait_ready();
      sync_pe();
      fill(255, 255, 255, 0, 0, 0, 0, 0, 0, 0);
      collect("sq10", 10);

      // square P=8 with D=0, then D=8
      send_cfg(MODE_SQUARE, 8, 0, 0);
      wait_ready();
      sync_pe();
      fill(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      collect("sq_d0", 8);
      send_cfg(MODE_SQUARE, 8, 8, 0);
      wait_ready();
      sync_pe();
      fill(255, 255, 255, 255, 255, 255, 255, 255, 0, 0);
      collect("sq_d8", 8);

      // sawtooth P=8 step=40
      send_cfg(MODE_SAW, 8, 0, 40);
      wait_ready();
      sync_pe();
      fill(40, 80, 120, 160, 200, 240, 255, 0, 0, 0);
      collect("saw", 8);

      // freeze with enable=0 while the ramp shows 120
      sync_pe();
      for (int i = 1; i <= 4; i++) @(negedge clk);
      chk("frz_pre", 32'(wave_out), 120);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("frz_wave", 32'(wave_out), 120);
         chk("frz_pe", 32'(period_end), 0);
      end
      enable = 1'b1;
      @(negedge clk);
      chk("frz_resume", 32'(wave_out), 160);

      // triangle P=8 step=100
      send_cfg(MODE_TRI, 8, 0, 100);
      wait_ready();
      sync_pe();
`ifdef WAVE_GEN_TRIANGLE_EN
      fill(100, 200, 255, 255, 155, 55, 0, 0, 0, 0);
`else
      fill(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
      collect("tri", 8);

      // offer on a period_end cycle, second offer held off while full
      send_cfg(MODE_SQUARE, 10, 3, 0);
      wait_ready();
      sync_pe();
      drive_cfg(MODE_SQUARE, 6, 2, 0);
      cfg_if.cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      drive_cfg(MODE_SQUARE, 4, 1, 0);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         exp_p = (n == 10) || (n == 16) || (n == 20);
         exp_r = (n == 11) || (n >= 17);
         chk($sformatf("hs_%0d", n), {30'd0, cfg_if.cfg_ready, period_end}, {30'd0, exp_r, exp_p});
         if (n == 11) begin
            @(posedge clk);
            #1;
            cfg_if.cfg_valid = 1'b0;
         end
      end

      // asynchronous reset mid-period with a full shadow
      send_cfg(MODE_SAW, 8, 0, 40);
      wait_ready();
      sync_pe();
      for (int i = 1; i <= 3; i++) @(negedge clk);
      drive_cfg(MODE_SQUARE, 5, 2, 0);
      cfg_if.cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_if.cfg_valid = 1'b0;
      chk("pre_rst_wave", 32'(wave_out), 120);
      chk("pre_rst_ready", 32'(cfg_if.cfg_ready), 0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_wave", 32'(wave_out), 0);
      chk("arst_ready", 32'(cfg_if.cfg_ready), 1);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("silent", {30'd0, wave_out == 8'd0, period_end}, {30'd0, 1'b1, 1'b0});
      end
      send_cfg(MODE_SQUARE, 4, 2, 0);
      wait_ready();
      sync_pe();
      fill(255, 255, 0, 0, 0, 0, 0, 0, 0, 0);
      collect("post_rst", 4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
